// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct codes, MDU state encoding
// and the instruction-class decode helpers used by the stall controller.
package pipe_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Instructions that start the multiplier/divider.
    function automatic logic is_mdu_op(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_SPECIAL) &&
               (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
    endfunction

    // Anything that touches HI/LO and must wait for a pending result.
    function automatic logic is_mdu_class(input logic [5:0] op, input logic [5:0] fn);
        return is_mdu_op(op, fn) ||
               ((op == OP_SPECIAL) &&
                (fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO));
    endfunction

    function automatic logic is_div(input logic [5:0] fn);
        return (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-facing bundle of the stall controller: instruction words in,
// stage enables / flush / MDU status out.
interface pipe_stall_ctrl_if;
    import pipe_defs::*;

    // No handshake: IR_D/IR_E are sampled combinationally each cycle and the
    // enables/flush respond in the same cycle; en_D=0 holds D, flush_E=1 inserts
    // a bubble into E on the coming edge.
    logic [31:0] IR_D;
    logic [31:0] IR_E;
    logic        en_F;
    logic        en_D;
    logic        flush_E;
    logic        en_M;
    logic        en_W;
    logic        mdu_start;
    logic        mdu_busy;
    logic [31:0] stall_cnt;
    mdu_state_e  mdu_state;

    modport master (
        output IR_D, IR_E,
        input  en_F, en_D, flush_E, en_M, en_W, mdu_start, mdu_busy, stall_cnt, mdu_state
    );

    modport slave (
        input  IR_D, IR_E,
        output en_F, en_D, flush_E, en_M, en_W, mdu_start, mdu_busy, stall_cnt, mdu_state
    );

endinterface

// File: rtl/pipe_stall_ctrl_timer.sv
// MDU busy timer: after a start it stays BUSY for lat-1 cycles, tracking
// when HI/LO will be written.
module mdu_busy_timer
    import pipe_defs::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] lat,
    output logic             busy,
    output mdu_state_e       state
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE: begin
                // A single-cycle op finishes in its start cycle and never raises busy.
                if (start && (lat > CNT_W'(1))) begin
                    state_d = MDU_BUSY;
                    cnt_d   = lat - CNT_W'(1);
                end
            end
            MDU_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy  = (state_q == MDU_BUSY);
    assign state = state_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use and
// HI/LO hazard detection, F/D enables, D->E bubble and a stall-cycle counter.
module pipe_stall_ctrl
    import pipe_defs::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stall_ctrl_if.slave   bus
);

    logic [5:0] op_d, fn_d, op_e, fn_e;
    logic [4:0] rs_d, rt_d, rt_e;
    logic       reads_rs_d, reads_rt_d;
    logic       stall_lu, stall_md, stall;
    logic       mdu_start, mdu_busy;
    logic [CNT_W-1:0] mdu_lat;
    mdu_state_e mdu_state;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        unused_ir_bits;

    assign op_d = bus.IR_D[31:26];
    assign rs_d = bus.IR_D[25:21];
    assign rt_d = bus.IR_D[20:16];
    assign fn_d = bus.IR_D[5:0];
    assign op_e = bus.IR_E[31:26];
    assign rt_e = bus.IR_E[20:16];
    assign fn_e = bus.IR_E[5:0];
    assign unused_ir_bits = ^{bus.IR_D[15:6], bus.IR_E[25:21], bus.IR_E[15:6]};

    assign reads_rs_d = !(op_d == OP_J || op_d == OP_JAL || op_d == OP_LUI);
    assign reads_rt_d = (op_d == OP_SPECIAL) || (op_d == OP_BEQ) ||
                        (op_d == OP_BNE) || (op_d == OP_SW);

    // $0 is hardwired, so a load into it never creates a dependency.
    assign stall_lu = (op_e == OP_LW) && (rt_e != 5'd0) &&
                      (((rs_d == rt_e) && reads_rs_d) || ((rt_d == rt_e) && reads_rt_d));

    // An MDU op arriving in E while busy is ignored rather than restarting the timer.
    assign mdu_start = !reset && !mdu_busy && is_mdu_op(op_e, fn_e);
    assign mdu_lat   = is_div(fn_e) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    assign stall_md = is_mdu_class(op_d, fn_d) && (mdu_busy || mdu_start);
    assign stall    = !reset && (stall_lu || stall_md);

    mdu_busy_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (mdu_start),
        .lat   (mdu_lat),
        .busy  (mdu_busy),
        .state (mdu_state)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.en_F      = ~stall;
    assign bus.en_D      = ~stall;
    assign bus.flush_E   = stall;
    assign bus.en_M      = 1'b1;
    assign bus.en_W      = 1'b1;
    assign bus.mdu_start = mdu_start;
    assign bus.mdu_busy  = mdu_busy;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.mdu_state = mdu_state;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: the driver plays the pipeline cycle by
// cycle and queues the expected outputs; the monitor checks them at negedge.
module tb_pipe_stall_ctrl;
    import pipe_defs::*;

    localparam int W = 39;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus();

    pipe_stall_ctrl #(
        .MULT_LAT (5),
        .DIV_LAT  (10),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic         obs      = 1'b0;
    logic         fin      = 1'b0;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        logic [4:0] s, t, d;
        s = 5'(rs); t = 5'(rt); d = 5'(rd);
        return {OP_SPECIAL, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] s, t;
        s = 5'(rs); t = 5'(rt);
        return {op, s, t, imm};
    endfunction

    // {en_F, en_D, flush_E, en_M, en_W, mdu_start, mdu_busy, stall_cnt}
    task automatic step(input string nm, input logic rst, input logic [31:0] ir_d,
                        input logic [31:0] ir_e, input logic stl, input logic start,
                        input logic busy, input logic [31:0] cnt);
        reset    = rst;
        bus.IR_D = ir_d;
        bus.IR_E = ir_e;
        exp_q.push_back({~stl, ~stl, stl, 1'b1, 1'b1, start, busy, cnt});
        name_q.push_back(nm);
        obs = 1'b1;
        @(posedge clk);
        #1;
        obs = 1'b0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] act, expv;
        string        nm;
        if (obs) begin
            act = {bus.en_F, bus.en_D, bus.flush_E, bus.en_M, bus.en_W,
                   bus.mdu_start, bus.mdu_busy, bus.stall_cnt};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL no_expectation got %h", act);
            end else begin
                expv = exp_q.pop_front();
                nm   = name_q.pop_front();
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL %s at %0t: got en_F/en_D/flush/M/W/start/busy=%b cnt=%0d, expected %b cnt=%0d",
                             nm, $time, act[38:32], act[31:0], expv[38:32], expv[31:0]);
                end
            end
        end
        if (fin) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        logic [31:0] lw8, addu8, lw0, addu0, j8, lui8, addi8, sw8, beq8;
        logic [31:0] mult, mflo, mflo8, div, divu;
        lw8   = itype(OP_LW, 1, 8, 16'h0000);
        addu8 = rtype(8, 2, 9, 6'h21);
        lw0   = itype(OP_LW, 1, 0, 16'h0004);
        addu0 = rtype(0, 0, 9, 6'h21);
        j8    = itype(OP_J, 8, 8, 16'h0010);
        lui8  = itype(OP_LUI, 8, 8, 16'h1234);
        addi8 = itype(6'h08, 3, 8, 16'h0001);
        sw8   = itype(OP_SW, 3, 8, 16'h0000);
        beq8  = itype(OP_BEQ, 8, 4, 16'h0002);
        mult  = rtype(4, 5, 0, FN_MULT);
        mflo  = rtype(0, 0, 10, FN_MFLO);
        mflo8 = rtype(8, 0, 10, FN_MFLO);
        div   = rtype(4, 5, 0, FN_DIV);
        divu  = rtype(6, 7, 0, FN_DIVU);

        reset    = 1'b1;
        bus.IR_D = '0;
        bus.IR_E = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset masks hazards and MDU issue
        step("rst_hazard", 1, addu8, lw8, 0, 0, 0, 0);
        step("rst_mult",   1, mflo,  mult, 0, 0, 0, 0);

        // Load-use
        step("lu_stall",   0, addu8, lw8, 1, 0, 0, 0);
        step("lu_release", 0, addu8, '0,  0, 0, 0, 1);
        step("lw_r0",      0, addu0, lw0, 0, 0, 0, 1);
        step("lu_j",       0, j8,    lw8, 0, 0, 0, 1);
        step("lu_lui",     0, lui8,  lw8, 0, 0, 0, 1);
        step("lu_addi_rt", 0, addi8, lw8, 0, 0, 0, 1);
        step("lu_sw_rt",   0, sw8,   lw8, 1, 0, 0, 1);
        step("lu_sw_rel",  0, sw8,   '0,  0, 0, 0, 2);
        step("lu_beq_rs",  0, beq8,  lw8, 1, 0, 0, 2);
        step("lu_beq_rel", 0, beq8,  '0,  0, 0, 0, 3);

        // mult then mflo: 5 stall cycles
        step("mult_start", 0, mflo, mult, 1, 1, 0, 3);
        for (int i = 0; i < 4; i++) step("mult_hold", 0, mflo, '0, 1, 0, 1, 32'(4 + i));
        step("mult_free",  0, mflo, '0,   0, 0, 0, 8);
        step("mflo_in_e",  0, '0,   mflo, 0, 0, 0, 8);

        // div then divu: 10 stall cycles, then second start
        step("div_start",  0, divu, div, 1, 1, 0, 8);
        for (int i = 0; i < 9; i++) step("div_hold", 0, divu, '0, 1, 0, 1, 32'(9 + i));
        step("div_free",   0, divu, '0,   0, 0, 0, 18);
        step("divu_start", 0, '0,   divu, 0, 1, 0, 18);
        step("busy_ignore",0, '0,   mult, 0, 0, 1, 18);
        step("div_busy",   0, '0,   '0,   0, 0, 1, 18);

        // Reset mid-divide abandons the op
        step("rst_mid_div",0, '0,   '0,   0, 0, 1, 18);
        step("rst_apply",  1, '0,   '0,   0, 0, 1, 18);
        step("post_rst",   0, mflo, '0,   0, 0, 0, 0);
        step("post_rst_e", 0, '0,   mflo, 0, 0, 0, 0);

        // Load-use and HI/LO hazard together count once per cycle
        step("mult_lw",    0, lw8,   mult, 0, 1, 0, 0);
        step("both_stall", 0, mflo8, lw8,  1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step("md_hold", 0, mflo8, '0, 1, 0, 1, 32'(1 + i));
        step("md_free",    0, mflo8, '0,    0, 0, 0, 4);
        step("mflo8_in_e", 0, '0,    mflo8, 0, 0, 0, 4);

        fin = 1'b1;
        @(posedge clk);
        #20;
        $display("FAIL monitor_end: summary not reached");
        $fatal(1);
    end

endmodule
